// File: rtl/clahe_hist_accum_pp_if.sv
// Pixel stream, status and histogram read port of the CLAHE ping-pong histogram stage.
// The master side drives pixels and read requests; the slave side is the histogram block.
interface clahe_hist_accum_pp_if #(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned BIN_W      = 8,
    parameter int unsigned TILE_IDX_W = 6,
    parameter int unsigned CNT_W      = 16
);
    logic [PIX_W-1:0]      in_y;
    logic                  in_href;
    logic                  in_vsync;
    logic [TILE_IDX_W-1:0] tile_idx;
    logic                  ping_pong_flag;
    logic                  clear_busy;
    logic                  frame_done;
    logic                  overrun;
    logic                  rd_en;
    logic [TILE_IDX_W-1:0] rd_tile;
    logic [BIN_W-1:0]      rd_bin;
    logic [CNT_W-1:0]      rd_data;
    logic                  rd_valid;

    modport master (
        output in_y, in_href, in_vsync, tile_idx, rd_en, rd_tile, rd_bin,
        input  ping_pong_flag, clear_busy, frame_done, overrun, rd_data, rd_valid
    );

    modport slave (
        input  in_y, in_href, in_vsync, tile_idx, rd_en, rd_tile, rd_bin,
        output ping_pong_flag, clear_busy, frame_done, overrun, rd_data, rd_valid
    );
endinterface

// File: rtl/clahe_hist_accum_pp.sv
// Per-tile luma histogram with ping-pong banks: 3-stage read-modify-write accumulate with
// forwarding, bank swap and clear on each frame start, registered read port on the idle bank.
module clahe_hist_accum_pp #(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned BIN_W      = 8,
    parameter int unsigned TILE_IDX_W = 6,
    parameter int unsigned CNT_W      = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    clahe_hist_accum_pp_if.slave bus
);
    localparam int unsigned ADDR_W = TILE_IDX_W + BIN_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StClear, StAccum} state_e;

    state_e            state_q;
    logic              vsync_q, flag_q, clear_busy_q, frame_done_q, overrun_q;
    logic [1:0]        drain_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              vs_edge, clr_we;
    logic [BIN_W-1:0]  pix_bin;
    logic [ADDR_W-1:0] pix_addr, rd_addr;

    logic              s0_valid_q, s0_bank_q, s1_valid_q, s1_bank_q, s2_valid_q, s2_bank_q;
    logic [ADDR_W-1:0] s0_addr_q, s1_addr_q, s2_addr_q;
    logic [CNT_W-1:0]  s1_rdata_q, s2_cnt_q, s1_cur, s1_inc;
    logic              s1_fwd;

    logic [CNT_W-1:0]  mem0 [DEPTH];
    logic [CNT_W-1:0]  mem1 [DEPTH];
    logic              rd_valid_q;
    logic [CNT_W-1:0]  rd_data_q;

    assign vs_edge  = bus.in_vsync & ~vsync_q;
    assign pix_bin  = BIN_W'(bus.in_y >> (PIX_W - BIN_W));
    assign pix_addr = {bus.tile_idx, pix_bin};
    assign rd_addr  = {bus.rd_tile, bus.rd_bin};
    // Clear writes start only once the two in-flight pipeline stages have drained.
    assign clr_we   = (state_q == StClear) && !vs_edge && (drain_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vsync_q      <= 1'b0;
            flag_q       <= 1'b0;
            clear_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            drain_q      <= 2'd0;
            clr_addr_q   <= '0;
        end else begin
            vsync_q      <= bus.in_vsync;
            frame_done_q <= 1'b0;
            if (vs_edge) begin
                flag_q       <= ~flag_q;
                state_q      <= StClear;
                clear_busy_q <= 1'b1;
                drain_q      <= 2'd2;
                clr_addr_q   <= '0;
                if (state_q == StAccum) frame_done_q <= 1'b1;
                if (state_q == StClear) overrun_q <= 1'b1;
            end else if (state_q == StClear) begin
                if (drain_q != 2'd0) begin
                    drain_q <= drain_q - 2'd1;
                end else if (&clr_addr_q) begin
                    state_q      <= StAccum;
                    clear_busy_q <= 1'b0;
                end else begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                end
            end
            if ((state_q == StClear) && bus.in_href) overrun_q <= 1'b1;
        end
    end

    always_comb begin
        s1_fwd = s2_valid_q && (s2_bank_q == s1_bank_q) && (s2_addr_q == s1_addr_q);
        s1_cur = s1_fwd ? s2_cnt_q : s1_rdata_q;
        s1_inc = (&s1_cur) ? s1_cur : s1_cur + 1'b1;
    end

    // Each stage carries its own bank bit so pixels in flight at a swap land in the old bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_bank_q  <= 1'b0;
            s0_addr_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_bank_q  <= 1'b0;
            s2_addr_q  <= '0;
            s2_cnt_q   <= '0;
        end else begin
            s0_valid_q <= bus.in_href && (state_q == StAccum);
            s0_bank_q  <= flag_q;
            s0_addr_q  <= pix_addr;
            s1_valid_q <= s0_valid_q;
            s1_bank_q  <= s0_bank_q;
            s1_addr_q  <= s0_addr_q;
            s2_valid_q <= s1_valid_q;
            s2_bank_q  <= s1_bank_q;
            s2_addr_q  <= s1_addr_q;
            s2_cnt_q   <= s1_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we && !flag_q) begin
            mem0[clr_addr_q] <= '0;
        end else if (s1_valid_q && !s1_bank_q) begin
            mem0[s1_addr_q] <= s1_inc;
        end
        if (clr_we && flag_q) begin
            mem1[clr_addr_q] <= '0;
        end else if (s1_valid_q && s1_bank_q) begin
            mem1[s1_addr_q] <= s1_inc;
        end
        s1_rdata_q <= s0_bank_q ? mem1[s0_addr_q] : mem0[s0_addr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= flag_q ? mem0[rd_addr] : mem1[rd_addr];
        end
    end

    assign bus.ping_pong_flag = flag_q;
    assign bus.clear_busy     = clear_busy_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.overrun        = overrun_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.rd_valid       = rd_valid_q;
endmodule
